// File: rtl/sr_mc_pkg.sv
// Shared types and encodings for the multi-cycle schoolRISCV control unit.
// The opcode and ALU encodings match the single-cycle decoder.
package sr_mc_pkg;

  localparam logic [6:0] RVOP_ADDI = 7'b0010011;
  localparam logic [6:0] RVOP_BR   = 7'b1100011;
  localparam logic [6:0] RVOP_LUI  = 7'b0110111;
  localparam logic [6:0] RVOP_ALU  = 7'b0110011;
  localparam logic [6:0] RVOP_P    = 7'b1110111;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_OR     = 3'b001;
  localparam logic [2:0] ALU_SRL    = 3'b010;
  localparam logic [2:0] ALU_SLTU   = 3'b011;
  localparam logic [2:0] ALU_SUB    = 3'b100;
  localparam logic [2:0] ALU_KSLL8  = 3'b101;
  localparam logic [2:0] ALU_KSLRA8 = 3'b110;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_TRAP
  } state_e;

  typedef struct packed {
    logic       branch;
    logic       condZero;
    logic       regWrite;
    logic       aluSrc;
    logic       wdSrc;
    logic [2:0] aluControl;
    logic       aluRounding;
    logic       valid;
  } ctrl_t;

endpackage

// File: rtl/sr_mc_control_decode.sv
// Combinational instruction decoder: maps IR fields to the control struct.
// Unmatched encodings come out with valid=0.
module sr_mc_decode
  import sr_mc_pkg::*;
(
  input  logic [6:0] cmdOp_i,
  input  logic [2:0] cmdF3_i,
  input  logic [6:0] cmdF7_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o            = '0;
    ctrl_o.valid      = 1'b1;
    ctrl_o.aluControl = ALU_ADD;
    casez ({cmdF7_i, cmdF3_i, cmdOp_i})
      {7'b0000000, 3'b000, RVOP_ALU}: ctrl_o.regWrite = 1'b1;
      {7'b0000000, 3'b110, RVOP_ALU}: begin ctrl_o.regWrite = 1'b1; ctrl_o.aluControl = ALU_OR;   end
      {7'b0000000, 3'b101, RVOP_ALU}: begin ctrl_o.regWrite = 1'b1; ctrl_o.aluControl = ALU_SRL;  end
      {7'b0000000, 3'b011, RVOP_ALU}: begin ctrl_o.regWrite = 1'b1; ctrl_o.aluControl = ALU_SLTU; end
      {7'b0100000, 3'b000, RVOP_ALU}: begin ctrl_o.regWrite = 1'b1; ctrl_o.aluControl = ALU_SUB;  end
      {7'b0101100, 3'b000, RVOP_P}:   begin ctrl_o.regWrite = 1'b1; ctrl_o.aluControl = ALU_KSLL8; end
      {7'b0101111, 3'b000, RVOP_P}:   begin ctrl_o.regWrite = 1'b1; ctrl_o.aluControl = ALU_KSLRA8; end
      {7'b0110111, 3'b000, RVOP_P}: begin
        ctrl_o.regWrite    = 1'b1;
        ctrl_o.aluControl  = ALU_KSLRA8;
        ctrl_o.aluRounding = 1'b1;
      end
      {7'b0111110, 3'b000, RVOP_P}: begin
        ctrl_o.regWrite   = 1'b1;
        ctrl_o.aluSrc     = 1'b1;
        ctrl_o.aluControl = ALU_KSLL8;
      end
      {7'b???????, 3'b000, RVOP_ADDI}: begin ctrl_o.regWrite = 1'b1; ctrl_o.aluSrc = 1'b1; end
      {7'b???????, 3'b???, RVOP_LUI}:  begin ctrl_o.regWrite = 1'b1; ctrl_o.wdSrc = 1'b1; end
      {7'b???????, 3'b000, RVOP_BR}: begin
        ctrl_o.branch     = 1'b1;
        ctrl_o.condZero   = 1'b1;
        ctrl_o.aluControl = ALU_SUB;
      end
      {7'b???????, 3'b001, RVOP_BR}: begin
        ctrl_o.branch     = 1'b1;
        ctrl_o.aluControl = ALU_SUB;
      end
      default: ctrl_o.valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/sr_mc_control.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control unit with imem req/ack handshake.
// Optional retired-instruction counter: define SR_MC_RETIRE_CNT_EN.
module sr_mc_control
  import sr_mc_pkg::*;
#(
  parameter int unsigned RETIRE_CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       halt,
  input  logic       imemAck,
  input  logic [6:0] cmdOp,
  input  logic [2:0] cmdF3,
  input  logic [6:0] cmdF7,
  input  logic       aluZero,
  output logic       imemReq,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       pcSrc,
  output logic       regWrite,
  output logic       aluSrc,
  output logic       wdSrc,
  output logic [2:0] aluControl,
  output logic       aluRounding,
  output logic       retire,
  output logic       illegal
`ifdef SR_MC_RETIRE_CNT_EN
  ,
  output logic [RETIRE_CNT_W-1:0] retireCnt
`endif
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  ctrl_t  dec;

  sr_mc_decode u_decode (
    .cmdOp_i (cmdOp),
    .cmdF3_i (cmdF3),
    .cmdF7_i (cmdF7),
    .ctrl_o  (dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    imemReq     = 1'b0;
    irWrite     = 1'b0;
    pcWrite     = 1'b0;
    pcSrc       = 1'b0;
    regWrite    = 1'b0;
    aluSrc      = 1'b0;
    wdSrc       = 1'b0;
    aluControl  = '0;
    aluRounding = 1'b0;
    retire      = 1'b0;
    illegal     = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        imemReq = !halt;
        if (!halt && imemAck) begin
          irWrite = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ctrl_d = dec;
        if (!dec.valid)     state_d = ST_TRAP;
        else if (dec.wdSrc) state_d = ST_WB;
        else                state_d = ST_EXEC;
      end
      ST_EXEC: begin
        aluControl  = ctrl_q.aluControl;
        aluSrc      = ctrl_q.aluSrc;
        aluRounding = ctrl_q.aluRounding;
        if (ctrl_q.branch) begin
          pcSrc   = (aluZero == ctrl_q.condZero);
          pcWrite = 1'b1;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        regWrite    = ctrl_q.regWrite;
        wdSrc       = ctrl_q.wdSrc;
        aluControl  = ctrl_q.aluControl;
        aluSrc      = ctrl_q.aluSrc;
        aluRounding = ctrl_q.aluRounding;
        pcWrite     = 1'b1;
        retire      = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_TRAP: illegal = !ctrl_q.valid;
      default: state_d = ST_FETCH;
    endcase
    // Reset is async: squash every output in the reset cycle itself.
    if (rst) begin
      imemReq     = 1'b0;
      irWrite     = 1'b0;
      pcWrite     = 1'b0;
      pcSrc       = 1'b0;
      regWrite    = 1'b0;
      aluSrc      = 1'b0;
      wdSrc       = 1'b0;
      aluControl  = '0;
      aluRounding = 1'b0;
      retire      = 1'b0;
      illegal     = 1'b0;
    end
  end

`ifdef SR_MC_RETIRE_CNT_EN
  logic [RETIRE_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (retire && state_q != ST_TRAP) begin
      cnt_q <= cnt_q + RETIRE_CNT_W'(1);
    end
  end

  assign retireCnt = cnt_q;
`endif

endmodule

// File: tb/tb_sr_mc_control.sv
// Directed bench for sr_mc_control: per-cycle expected output vectors via a queue.
module tb_sr_mc_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       halt = 1'b0;
  logic       imemAck = 1'b0;
  logic [6:0] cmdOp = '0;
  logic [2:0] cmdF3 = '0;
  logic [6:0] cmdF7 = '0;
  logic       aluZero = 1'b0;
  logic       imemReq, irWrite, pcWrite, pcSrc, regWrite, aluSrc, wdSrc;
  logic [2:0] aluControl;
  logic       aluRounding, retire, illegal;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];

`ifdef SR_MC_RETIRE_CNT_EN
  logic [3:0] retireCnt;
  sr_mc_control #(.RETIRE_CNT_W(4)) dut (
    .clk(clk), .rst(rst), .halt(halt), .imemAck(imemAck), .cmdOp(cmdOp), .cmdF3(cmdF3),
    .cmdF7(cmdF7), .aluZero(aluZero), .imemReq(imemReq), .irWrite(irWrite), .pcWrite(pcWrite),
    .pcSrc(pcSrc), .regWrite(regWrite), .aluSrc(aluSrc), .wdSrc(wdSrc), .aluControl(aluControl),
    .aluRounding(aluRounding), .retire(retire), .illegal(illegal), .retireCnt(retireCnt)
  );
`else
  sr_mc_control dut (
    .clk(clk), .rst(rst), .halt(halt), .imemAck(imemAck), .cmdOp(cmdOp), .cmdF3(cmdF3),
    .cmdF7(cmdF7), .aluZero(aluZero), .imemReq(imemReq), .irWrite(irWrite), .pcWrite(pcWrite),
    .pcSrc(pcSrc), .regWrite(regWrite), .aluSrc(aluSrc), .wdSrc(wdSrc), .aluControl(aluControl),
    .aluRounding(aluRounding), .retire(retire), .illegal(illegal)
  );
`endif

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // {imemReq, irWrite, pcWrite, pcSrc, regWrite, aluSrc, wdSrc, aluControl, aluRounding, retire, illegal}
  function automatic logic [12:0] ov(input logic req, input logic irw, input logic pcw,
                                     input logic pcs, input logic rw, input logic as_,
                                     input logic wds, input logic [2:0] ac, input logic rnd,
                                     input logic ret, input logic ill);
    return {req, irw, pcw, pcs, rw, as_, wds, ac, rnd, ret, ill};
  endfunction

  task automatic chk(input string tag, input logic [12:0] e);
    logic [12:0] got, want;
    exp_q.push_back(e);
    @(negedge clk);
    got  = {imemReq, irWrite, pcWrite, pcSrc, regWrite, aluSrc, wdSrc, aluControl,
            aluRounding, retire, illegal};
    want = exp_q.pop_front();
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic alu_instr(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                           input logic [6:0] op, input logic [2:0] ac, input logic as_,
                           input logic rnd);
    cmdF7 = f7; cmdF3 = f3; cmdOp = op; imemAck = 1'b1;
    chk({tag, ".fetch"}, ov(1, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0));
    chk({tag, ".decode"}, '0);  // ack still high here and must be ignored
    imemAck = 1'b0;
    chk({tag, ".exec"}, ov(0, 0, 0, 0, 0, as_, 0, ac, rnd, 0, 0));
    chk({tag, ".wb"}, ov(0, 0, 1, 0, 1, as_, 0, ac, rnd, 1, 0));
  endtask

  task automatic br_instr(input string tag, input logic [2:0] f3, input logic zero,
                          input logic taken);
    cmdF7 = 7'b1100110; cmdF3 = f3; cmdOp = 7'b1100011; imemAck = 1'b1;
    chk({tag, ".fetch"}, ov(1, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0));
    imemAck = 1'b0;
    chk({tag, ".decode"}, '0);
    aluZero = zero;
    chk({tag, ".exec"}, ov(0, 0, 1, taken, 0, 0, 0, 3'b100, 0, 1, 0));
    aluZero = 1'b0;
  endtask

  initial begin
    chk("reset", '0);
    rst = 1'b0;
    chk("fetch.idle", ov(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0));

    alu_instr("add",     7'b0000000, 3'b000, 7'b0110011, 3'b000, 0, 0);
    chk("add.next", ov(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0));
    alu_instr("sub",     7'b0100000, 3'b000, 7'b0110011, 3'b100, 0, 0);
    alu_instr("or",      7'b0000000, 3'b110, 7'b0110011, 3'b001, 0, 0);
    alu_instr("srl",     7'b0000000, 3'b101, 7'b0110011, 3'b010, 0, 0);
    alu_instr("sltu",    7'b0000000, 3'b011, 7'b0110011, 3'b011, 0, 0);
    alu_instr("addi",    7'b1010101, 3'b000, 7'b0010011, 3'b000, 1, 0);
    alu_instr("ksll8",   7'b0101100, 3'b000, 7'b1110111, 3'b101, 0, 0);
    alu_instr("kslra8",  7'b0101111, 3'b000, 7'b1110111, 3'b110, 0, 0);
    alu_instr("kslra8u", 7'b0110111, 3'b000, 7'b1110111, 3'b110, 0, 1);
    alu_instr("kslli8",  7'b0111110, 3'b000, 7'b1110111, 3'b101, 1, 0);

    br_instr("beq.taken", 3'b000, 1'b1, 1'b1);
    br_instr("beq.not",   3'b000, 1'b0, 1'b0);
    br_instr("bne.taken", 3'b001, 1'b0, 1'b1);
    br_instr("bne.not",   3'b001, 1'b1, 1'b0);

    cmdF7 = 7'b0011001; cmdF3 = 3'b101; cmdOp = 7'b0110111; imemAck = 1'b1;
    chk("lui.fetch", ov(1, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0));
    imemAck = 1'b0;
    chk("lui.decode", '0);
    chk("lui.wb", ov(0, 0, 1, 0, 1, 0, 1, 3'b000, 0, 1, 0));

    chk("halt.wait0", ov(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0));
    chk("halt.wait1", ov(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0));
    halt = 1'b1; imemAck = 1'b1;
    chk("halt.ackIgnored", '0);
    imemAck = 1'b0;
    chk("halt.hold", '0);
    halt = 1'b0;
    chk("halt.resume", ov(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0));
    alu_instr("or.afterHalt", 7'b0000000, 3'b110, 7'b0110011, 3'b001, 0, 0);

    cmdF7 = 7'b0000000; cmdF3 = 3'b000; cmdOp = 7'b1111111; imemAck = 1'b1;
    chk("trap.fetch", ov(1, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0));
    chk("trap.decode", '0);
    chk("trap.enter", ov(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1));
    chk("trap.sticky", ov(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1));
    imemAck = 1'b0;
    rst = 1'b1;
    chk("trap.reset", '0);
    rst = 1'b0;
    chk("trap.fetchAfterReset", ov(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0));

    cmdF7 = 7'b0100000; cmdF3 = 3'b000; cmdOp = 7'b0110011; imemAck = 1'b1;
    chk("rstwb.fetch", ov(1, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0));
    imemAck = 1'b0;
    chk("rstwb.decode", '0);
    chk("rstwb.exec", ov(0, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0, 0));
    rst = 1'b1;
    chk("rstwb.noWrite", '0);
    rst = 1'b0;
    chk("rstwb.fetch2", ov(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0));

`ifdef SR_MC_RETIRE_CNT_EN
    rst = 1'b1;
    chk("cnt.reset", '0);
    rst = 1'b0;
    checks++;
    assert (retireCnt === 4'd0) else begin
      errors++;
      $error("FAIL cnt.zero: observed=%0d expected=0", retireCnt);
    end
    for (int i = 0; i < 17; i++)
      alu_instr("cnt.addi", 7'b0000000, 3'b000, 7'b0010011, 3'b000, 1, 0);
    checks++;
    assert (retireCnt === 4'd1) else begin
      errors++;
      $error("FAIL cnt.wrap: observed=%0d expected=1", retireCnt);
    end
    imemAck = 1'b1;
    chk("cnt.rst.fetch", ov(1, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0));
    imemAck = 1'b0;
    chk("cnt.rst.decode", '0);
    chk("cnt.rst.exec", ov(0, 0, 0, 0, 0, 1, 0, 3'b000, 0, 0, 0));
    rst = 1'b1;
    chk("cnt.rst.wb", '0);
    rst = 1'b0;
    checks++;
    assert (retireCnt === 4'd0) else begin
      errors++;
      $error("FAIL cnt.afterReset: observed=%0d expected=0", retireCnt);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
